// File: rtl/iter_alu_pkg.sv
// Shared definitions for the iterative ALU: operation codes and FSM states.
package iter_alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle combinational unit: logic ops, add/sub with overflow, SLT, SLL
// and illegal-code decode. MULTU/DIVU are legal here but produce no result.
module alu_comb
  import iter_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             ovf,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic signed [WIDTH-1:0] sum;
  logic signed [WIDTH-1:0] diff;
  logic                    ovf_add;
  logic                    ovf_sub;
  logic                    slt;

  assign sum     = a + b;
  assign diff    = a + ~b + ONE;
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  // Signed less-than: the subtract sign is wrong exactly when it overflowed.
  assign slt     = diff[WIDTH-1] ^ ovf_sub;

  // Select the result and flags for the requested code.
  always_comb begin
    res     = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_ADD: begin
        res = sum;
        ovf = ovf_add;
      end
      OP_SUB: begin
        res = diff;
        ovf = ovf_sub;
      end
      OP_SLT:   res = {{(WIDTH-1){1'b0}}, slt};
      OP_SLL:   res = a << b[SHW-1:0];
      OP_MULTU: res = '0;
      OP_DIVU:  res = '0;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle ALU behind a valid/ready handshake. Single-cycle ops finish in
// one clock; MULTU (shift-add) and DIVU (restoring) take WIDTH iterations.
module iter_alu
  import iter_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataOut,
  output logic [WIDTH-1:0] dataHi,
  output logic             zero,
  output logic             ovf,
  output logic             dz,
  output logic             illegal
);

  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH-1);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  state_t           state;
  state_t           state_nxt;
  logic [SHW:0]     cnt;
  logic             xfer;
  logic             iter_last;
  logic             b_zero;

  logic [WIDTH-1:0] opr;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;

  alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
    .op      (op),
    .a       (dataA),
    .b       (dataB),
    .res     (alu_res),
    .ovf     (alu_ovf),
    .illegal (alu_ill)
  );

  assign xfer      = in_valid && in_ready;
  assign iter_last = (cnt == CNT_LAST);
  assign b_zero    = (dataB == '0);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = reset;
        if (xfer) begin
          if (op == OP_MULTU)                 state_nxt = ST_MUL;
          else if (op == OP_DIVU && !b_zero)  state_nxt = ST_DIV;
          else                                state_nxt = ST_DONE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (iter_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Iteration counter; cleared at every accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               cnt <= '0;
    else if (xfer)                            cnt <= '0;
    else if (state == ST_MUL || state == ST_DIV) cnt <= cnt + CNT_ONE;
  end

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opr} : '0);
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opr};

  // One iteration step: shift-add for MUL, restoring subtract for DIV.
  always_comb begin
    hi_nxt = acc_hi;
    lo_nxt = acc_lo;
    if (state == ST_MUL) begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (state == ST_DIV) begin
      if (!div_diff[WIDTH]) begin
        hi_nxt = div_diff[WIDTH-1:0];
        lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = div_sh[WIDTH-1:0];
        lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Working registers: acc_lo holds multiplier / dividend-quotient, opr the other operand.
  always_ff @(posedge clk) begin
    if (xfer) begin
      acc_hi <= '0;
      acc_lo <= (op == OP_MULTU) ? dataB : dataA;
      opr    <= (op == OP_MULTU) ? dataA : dataB;
    end else if (state == ST_MUL || state == ST_DIV) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
    end
  end

  // Registered results and flags; flags clear on every accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataOut <= '0;
      dataHi  <= '0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
      dz      <= 1'b0;
      illegal <= 1'b0;
    end else if (xfer) begin
      ovf     <= 1'b0;
      dz      <= 1'b0;
      illegal <= 1'b0;
      if (op == OP_MULTU || (op == OP_DIVU && !b_zero)) begin
        dataOut <= '0;
        dataHi  <= '0;
        zero    <= 1'b0;
      end else if (op == OP_DIVU) begin
        dataOut <= '1;
        dataHi  <= dataA;
        zero    <= 1'b0;
        dz      <= 1'b1;
      end else begin
        dataOut <= alu_res;
        dataHi  <= '0;
        zero    <= (alu_res == '0);
        ovf     <= alu_ovf;
        illegal <= alu_ill;
      end
    end else if ((state == ST_MUL || state == ST_DIV) && iter_last) begin
      dataOut <= lo_nxt;
      dataHi  <= hi_nxt;
      zero    <= (lo_nxt == '0);
    end
  end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, multi-cycle successor to the 32-bit datapath ALU.
- Keeps the legacy 3-bit operation codes and their results: AND, OR, ADD, SUB, SLT, SLL.
- Adds iterative unsigned multiply and divide that produce a HI/LO result pair, plus status flags.
- Sits in the EX stage of the CPU behind a valid/ready handshake; the pipeline stalls on in_ready low.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH), number of shift-amount bits taken from dataB.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- op  in  4  operation code (see Behaviour)
- dataA  in  WIDTH  operand A
- dataB  in  WIDTH  operand B
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- dataOut  out  WIDTH  result, or LO half for MULTU/DIVU
- dataHi  out  WIDTH  HI half: product upper bits or remainder; 0 for other ops
- zero  out  1  dataOut == 0
- ovf  out  1  signed overflow on ADD/SUB; 0 otherwise
- dz  out  1  DIVU with dataB == 0
- illegal  out  1  op code not listed below

Behaviour:
- Clock/reset: one clock domain. reset low forces IDLE asynchronously and clears all registered outputs to 0; in_ready goes to 1 once reset is released.
- Op codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (A + ~B + 1).
  - 0111 SLT (signed, result 1 or 0, computed from the subtract sign XOR overflow).
  - 0101 SLL (dataA << dataB[SHW-1:0]).
  - 1000 MULTU {dataHi, dataOut} = A*B unsigned, 2*WIDTH bits.
  - 1001 DIVU dataOut = A/B, dataHi = A%B.
  - Any other code: dataOut = 0, dataHi = 0, illegal = 1, single-cycle.
- Handshake: a transfer occurs on in_valid & in_ready. Operands and op are captured at transfer; input changes after that have no effect.
- FSM states:
  - IDLE: in_ready = 1.
    - Single-cycle op → DONE.
    - MULTU → MUL, counter = 0.
    - DIVU with B == 0 → DONE with dz = 1, dataOut = all ones, dataHi = A.
    - DIVU otherwise → DIV.
  - MUL: shift-add, one multiplier bit per cycle; after WIDTH iterations → DONE.
  - DIV: restoring division, one quotient bit per cycle; after WIDTH iterations → DONE.
  - DONE: out_valid = 1, outputs registered and stable.
    - out_ready = 1 → IDLE, out_valid drops next cycle.
    - out_ready = 0 → hold indefinitely.
- in_ready = 0 in MUL, DIV and DONE. There is no back-to-back overlap; the consumer of a result must also free the block.
- Latency from the transfer edge N:
  - Single-cycle ops and DIVU-by-zero: out_valid at N+1.
  - MULTU/DIVU: out_valid at N+WIDTH+1.
- Flags:
  - zero reflects dataOut for every op.
  - ovf only for ADD/SUB: the operand signs match (B inverted for SUB) and the result sign differs.
  - Flags are valid only while out_valid = 1 and are cleared on the next accepted request.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. The shift amount ignores dataB bits above SHW-1.
- Reset mid-operation: the iteration is abandoned, the block returns to IDLE, and no out_valid pulse occurs.
- Counter: width SHW+1, so no wrap occurs before WIDTH iterations.

Decomposition:
- Package iter_alu_pkg holds:
  - op code localparams: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLL, OP_MULTU, OP_DIVU;
  - the FSM state encoding: ST_IDLE, ST_MUL, ST_DIV, ST_DONE.
- One sub-module: alu_comb (WIDTH). It is the combinational single-cycle unit covering logic, add/sub, SLT, SLL, ovf and illegal decode. The FSM, MUL/DIV datapath and output registers stay in iter_alu.

Test Plan (WIDTH = 32):
- ADD 0x7FFFFFFF + 1 → out_valid at N+1, dataOut = 0x80000000, ovf = 1, zero = 0. Then SUB 5 − 5 → dataOut = 0, zero = 1, ovf = 0.
- SLT −3 (0xFFFFFFFD) vs 2 → dataOut = 1. SLL 0x1 by dataB = 0x00000023 → dataOut = 0x00000008 (amount 3).
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → out_valid exactly at N+33, dataHi = 0xFFFFFFFE, dataOut = 0x00000001. in_ready = 0 for cycles N+1..N+33.
- DIVU 100 / 7 → dataOut = 14, dataHi = 2 at N+33. DIVU 9 / 0 → at N+1, dz = 1, dataOut = 0xFFFFFFFF, dataHi = 9.
- Back-pressure: hold out_ready = 0 for 5 cycles after a MULTU completes → outputs stable, in_ready = 0. A new in_valid is ignored until one cycle after out_ready = 1.
- Reset asserted at cycle N+10 of a DIVU → outputs 0 immediately, no out_valid. After release, op 1111 → illegal = 1, dataOut = 0 at N+1.
